fifo_uart_tx: RTL and testbench

Serial transmitter that drains the read side of the team's `FIFO_TOP`, which has 8-bit data and 16 entries. While enabled and the FIFO is non-empty, the block pops one byte and sends it as an 8N1 (or 8N2) UART frame, LSB first, at a fixed baud. It connects directly to `FIFO_TOP` `RD`/`EMPTY`/`RD_DATA`; producers only ever touch the FIFO write side.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/baud_tick_gen.sv | 17 +
 rtl/fifo_uart_tx.sv | 75 +++++++
 tb/tb_fifo_uart_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: types and constants shared by FIFO_TOP and its serial transmitter.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle tick every CLKS_PER_BIT cycles, restarted by clear.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_CLK,
  input  logic i_RST_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] r_cnt;
  assign tick = !clear && r_cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) r_cnt <= '0;
    else r_cnt <= (clear || tick) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops the show-ahead FIFO head and sends it as an LSB-first UART frame.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,
  input  logic                  i_TX_EN,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD,
  output logic                  o_TX,
  output logic                  o_BUSY
);
  import fifo_pkg::*;
  localparam int IW = $clog2(DATA_WIDTH);
  tx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_stop_idx;
  logic                  w_tick;
  logic                  w_clear;
  // gated by reset so an asserted reset never pops a non-empty FIFO
  assign RD      = i_RST_n && r_state == IDLE && i_TX_EN && !EMPTY;
  assign w_clear = r_state == IDLE;
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_CLK  (i_CLK),
    .i_RST_n(i_RST_n),
    .clear  (w_clear),
    .tick   (w_tick)
  );
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      o_TX       <= 1'b1;
      o_BUSY     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (RD) begin
          r_shift    <= RD_DATA;
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          o_TX       <= 1'b0;
          o_BUSY     <= 1'b1;
          r_state    <= START;
        end
        START: if (w_tick) begin
          o_TX    <= r_shift[0];
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          if (r_bit_idx == IW'(DATA_WIDTH - 1)) begin
            o_TX    <= 1'b1;
            r_state <= STOP;
          end else begin
            o_TX      <= r_shift[1];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          if (r_stop_idx == 1'(STOP_BITS - 1)) begin
            o_BUSY  <= 1'b0;
            r_state <= IDLE;
          end else r_stop_idx <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (1 and 2 stop bits) fed by queue FIFOs, checked against a frame timeline model.
module tb_fifo_uart_tx;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic empty[2];
  logic [7:0] rdata[2];
  logic rd[2], tx[2], busy[2];
  logic [7:0] fq[2][$];
  logic [7:0] rxq[2][$];
  int stq[2][$];
  logic [7:0] xq[$];
  int checks = 0, errors = 0, cyc = 0;
  int rd_cnt[2];
  int m_pop[2], m_free[2], rs[2];
  logic [10:0] m_frame[2];
  logic [7:0] rb[2];
  logic rxing[2], prev[2], pops[2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_TX_EN(en), .EMPTY(empty[0]), .RD_DATA(rdata[0]),
    .RD(rd[0]), .o_TX(tx[0]), .o_BUSY(busy[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_TX_EN(en), .EMPTY(empty[1]), .RD_DATA(rdata[1]),
    .RD(rd[1]), .o_TX(tx[1]), .o_BUSY(busy[1]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic fifo_upd();
    for (int i = 0; i < 2; i++) begin
      empty[i] = fq[i].size() == 0;
      rdata[i] = fq[i].size() == 0 ? 8'h00 : fq[i][0];
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fq[i].push_back(b);
    xq.push_back(b);
    fifo_upd();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_rx(input int i, input int period);
    check("rx_count", rxq[i].size(), xq.size());
    for (int k = 0; k < xq.size() && k < rxq[i].size(); k++) check("rx_byte", int'(rxq[i][k]), int'(xq[k]));
    if (period != 0)
      for (int k = 1; k < stq[i].size(); k++) check("start_period", stq[i][k] - stq[i][k-1], period);
    rxq[i].delete();
    stq[i].delete();
    xq.delete();
  endtask

  // timeline model: a pop at cycle k puts frame bit j on cycles k+j*C+1..k+(j+1)*C
  initial begin
    int s, len, d, j;
    logic e_rd, e_tx, e_busy;
    for (int i = 0; i < 2; i++) begin
      m_pop[i] = -100000; m_free[i] = 0; rxing[i] = 1'b0; prev[i] = 1'b1; rd_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s = i + 1;
        len = (9 + s) * C;
        if (!rst_n) begin
          m_pop[i] = -100000;
          m_free[i] = 0;
        end
        e_rd = rst_n && en && fq[i].size() > 0 && cyc >= m_free[i];
        if (e_rd) begin
          m_pop[i] = cyc;
          m_frame[i] = {2'b11, fq[i][0], 1'b0};
          m_free[i] = cyc + len + 1;
        end
        d = cyc - m_pop[i];
        e_busy = d >= 1 && d <= len;
        e_tx = e_busy ? m_frame[i][(d-1)/C] : 1'b1;
        check("rd", int'(rd[i]), int'(e_rd));
        check("tx", int'(tx[i]), int'(e_tx));
        check("busy", int'(busy[i]), int'(e_busy));
        check("rd_while_empty", int'(rd[i] && empty[i]), 0);
        pops[i] = rd[i];
        if (!rst_n) rxing[i] = 1'b0;
        else if (!rxing[i]) begin
          if (prev[i] && !tx[i]) begin
            rxing[i] = 1'b1;
            rs[i] = cyc;
            stq[i].push_back(cyc);
          end
        end else begin
          d = cyc - rs[i];
          if (d % C == C / 2) begin
            j = d / C;
            if (j == 0) check("start_bit", int'(tx[i]), 0);
            else if (j <= 8) rb[i][j-1] = tx[i];
            else check("stop_bit", int'(tx[i]), 1);
            if (j == 8 + s) begin
              rxq[i].push_back(rb[i]);
              rxing[i] = 1'b0;
            end
          end
        end
        prev[i] = tx[i];
      end
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        if (pops[i]) begin
          if (fq[i].size() > 0) void'(fq[i].pop_front());
          rd_cnt[i]++;
        end
      fifo_upd();
    end
  end

  initial begin
    int n;
    fifo_upd();
    #7;
    check("reset_tx", int'(tx[0]), 1);
    check("reset_rd", int'(rd[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    #6 rst_n = 1'b1;
    tick(200);
    check("idle_no_rd", rd_cnt[0], 0);
    rd_cnt[0] = 0;
    push(0, 8'hA5);
    tick(60);
    check_rx(0, 0);
    check("a5_rd_cnt", rd_cnt[0], 1);
    check("a5_empty", int'(empty[0]), 1);
    rd_cnt[0] = 0;
    for (int b = 0; b < 16; b++) push(0, 8'(b));
    tick(16 * 41 + 20);
    check_rx(0, 41);
    check("burst_rd_cnt", rd_cnt[0], 16);
    check("burst_empty", int'(empty[0]), 1);
    rd_cnt[0] = 0;
    push(0, 8'h3C);
    push(0, 8'h11);
    push(0, 8'h22);
    tick(10);
    en = 1'b0;
    tick(100);
    check("en_hold_rd_cnt", rd_cnt[0], 1);
    check("en_hold_level", fq[0].size(), 2);
    en = 1'b1;
    tick(100);
    check_rx(0, 0);
    check("en_resume_rd_cnt", rd_cnt[0], 3);
    rd_cnt[0] = 0;
    fq[0].push_back(8'h5A);
    push(0, 8'h77);
    xq.delete();
    xq.push_back(8'h77);
    tick(18);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_tx", int'(tx[0]), 1);
    check("midframe_rst_rd", int'(rd[0]), 0);
    check("midframe_rst_busy", int'(busy[0]), 0);
    tick(3);
    rst_n = 1'b1;
    tick(60);
    check_rx(0, 0);
    check("rst_rd_cnt", rd_cnt[0], 2);
    check("rst_empty", int'(empty[0]), 1);
    repeat (6) begin
      rd_cnt[0] = 0;
      n = $urandom_range(1, 5);
      en = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) push(0, 8'($urandom));
      tick($urandom_range(5, 60));
      en = 1'b1;
      tick(n * 41 + 50);
      check_rx(0, 0);
      check("rand_rd_cnt", rd_cnt[0], n);
    end
    rd_cnt[1] = 0;
    for (int k = 0; k < 3; k++) push(1, 8'hFF);
    tick(3 * 45 + 20);
    check_rx(1, 45);
    check("stop2_rd_cnt", rd_cnt[1], 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
